operand_entry: RTL and testbench
================================

OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive clk cycles a new key level must persist before it is accepted (10 ms at 50 MHz); legal range >= 2.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 key_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy.
REQ-005 sw  input  3  operand switches, quasi-static, sampled only on an accepted press.
REQ-006 sw_cin  input  1  carry-in switch, sampled only on an accepted press.
REQ-007 a  output  3  captured operand A, registered; feeds the 3-bit adder / seven-segment stage.
REQ-008 b  output  3  captured operand B, registered.
REQ-009 cin  output  1  captured carry-in, registered.
REQ-010 valid  output  1  high while a, b, cin form a complete operand set.
REQ-011 stage  output  2  current FSM state encoding, for board LEDs: 00 ENTER_A, 01 ENTER_B, 10 ENTER_CIN, 11 SHOW.

Function
REQ-012 key_n SHALL pass through a two-flop synchronizer; only the second flop output (key_s) is used downstream.
REQ-013 Debouncer SHALL hold a debounced level (deb) and a counter: counter clears whenever key_s == deb; increments each cycle key_s != deb; on the cycle counter == DEBOUNCE_CYCLES-1 with key_s != deb still true, deb <= key_s and counter <= 0.
REQ-014 Counter width SHALL hold DEBOUNCE_CYCLES-1 without overflow; counter SHALL never wrap.
REQ-015 Any key_s excursion shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave deb unchanged.
REQ-016 press SHALL be a registered internal pulse, high for exactly one cycle on the cycle after deb transitions 1 -> 0; a deb 0 -> 1 (release) transition SHALL generate no event.
REQ-017 Holding the key low indefinitely SHALL produce exactly one press (no auto-repeat).
REQ-018 Latency: press high during the cycle following rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples key_n low as edge 1, given key_n held low throughout.
REQ-019 FSM transitions occur only on press: ENTER_A -> ENTER_B -> ENTER_CIN -> SHOW -> ENTER_A; no press, no change.
REQ-020 press in ENTER_A: a <= sw. press in ENTER_B: b <= sw. press in ENTER_CIN: cin <= sw_cin and valid <= 1, same edge as the state change to SHOW.
REQ-021 press in SHOW: valid <= 0, a <= 0, b <= 0, cin <= 0, state <= ENTER_A, all on one edge.
REQ-022 a, b, cin SHALL not change except as in REQ-020/021; sw/sw_cin changes outside a press SHALL have no effect.
REQ-023 valid SHALL be 1 exactly when stage == 11.

Reset
REQ-024 reset high at a clk edge SHALL set: state ENTER_A (stage 00), a 0, b 0, cin 0, valid 0, both synchronizer flops 1, deb 1, counter 0, press 0.
REQ-025 reset SHALL override any simultaneous press or debounce completion.
REQ-026 reset asserted mid-sequence (any state, any counter value) SHALL discard partial operands; a key held low across reset deassertion SHALL be re-debounced from counter 0 and then yield one press.

Verification (DEBOUNCE_CYCLES = 4 for simulation)
REQ-027 Reset, then key_n low held 20 cycles -> single press 7 edges after first low sample; stage 00 -> 01; a = sw value at that press.
REQ-028 key_n low pulses of 1, 2, 3 cycles separated by 5 high cycles -> no press, stage stays 00, counter returns to 0.
REQ-029 Full sequence sw=5, sw=6, sw_cin=1 with clean presses -> a=5, b=6, cin=1, valid=1, stage=11; downstream sum reads 12.
REQ-030 In SHOW, toggle sw and sw_cin without pressing -> a, b, cin, valid unchanged; next press -> all outputs 0, stage 00.
REQ-031 reset asserted in ENTER_CIN with a=7, b=7 -> next edge all outputs 0, stage 00; reset coincident with a press pulse -> reset values, no state advance.
REQ-032 key_n bouncing (alternating every cycle for 10 cycles) then held low 10 cycles -> exactly one press.

Source files
------------

// File: rtl/operand_entry.sv
// Pushbutton-driven operand entry: synchronizes and debounces an active-low key,
// then steps A -> B -> carry-in -> SHOW, capturing the switches on each accepted press.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [2:0] sw,
  input  logic       sw_cin,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       cin,
  output logic       valid,
  output logic [1:0] stage
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTER_A   = 2'b00,
    ENTER_B   = 2'b01,
    ENTER_CIN = 2'b10,
    SHOW      = 2'b11
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  state_t        r_state;
  logic [2:0]    r_a;
  logic [2:0]    r_b;
  logic          r_cin;
  logic          r_valid;
  logic          w_key_s;

  assign w_key_s = r_sync2;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // see pre-edge values of each other, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // the counter saturates at CNT_MAX by construction and so never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      r_press <= r_deb_d & ~r_deb;
      if (w_key_s == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_deb <= w_key_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_valid <= 1'b0;
    end else if (r_press) begin
      case (r_state)
        ENTER_A: begin
          r_a     <= sw;
          r_state <= ENTER_B;
        end
        ENTER_B: begin
          r_b     <= sw;
          r_state <= ENTER_CIN;
        end
        ENTER_CIN: begin
          r_cin   <= sw_cin;
          r_valid <= 1'b1;
          r_state <= SHOW;
        end
        default: begin
          r_a     <= '0;
          r_b     <= '0;
          r_cin   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ENTER_A;
        end
      endcase
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign cin   = r_cin;
  assign valid = r_valid;
  assign stage = r_state;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed vector table, hand-written
// debounce/reset corner sequences, then random key activity against a window model.
module tb_operand_entry;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [2:0] sw = 3'd0;
  logic       sw_cin = 1'b0;
  logic [2:0] a, b;
  logic       cin, valid;
  logic [1:0] stage;

  int n_checks = 0;
  int n_errors = 0;

  operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw), .sw_cin(sw_cin),
    .a(a), .b(b), .cin(cin), .valid(valid), .stage(stage)
  );

  always #5 clk = ~clk;

  // Reference model: a key level is accepted once the last DC synchronized
  // samples all differ from the accepted level; the press acts two edges later.
  logic       hist [0:DC];
  logic       m_deb = 1'b1, m_fell = 1'b0, m_press = 1'b0;
  logic [1:0] m_stage = 2'd0;
  logic [2:0] m_a = 3'd0, m_b = 3'd0;
  logic       m_cin = 1'b0;

  function automatic logic window_differs();
    for (int i = 1; i <= DC; i++)
      if (hist[i] == m_deb) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= DC; i++) hist[i] <= 1'b1;
      m_deb <= 1'b1; m_fell <= 1'b0; m_press <= 1'b0;
      m_stage <= 2'd0; m_a <= 3'd0; m_b <= 3'd0; m_cin <= 1'b0;
    end else begin
      if (m_press) begin
        case (m_stage)
          2'd0: m_a <= sw;
          2'd1: m_b <= sw;
          2'd2: m_cin <= sw_cin;
          default: begin m_a <= 3'd0; m_b <= 3'd0; m_cin <= 1'b0; end
        endcase
        m_stage <= m_stage + 2'd1;
      end
      m_press <= m_fell;
      m_fell  <= window_differs() && m_deb;
      if (window_differs()) m_deb <= ~m_deb;
      hist[0] <= key_n;
      for (int i = 1; i <= DC; i++) hist[i] <= hist[i-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; key_n = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic clean_press();
    key_n = 1'b0; cycles(10);
    key_n = 1'b1; cycles(10);
  endtask

  task automatic check_all(input string name, input logic [2:0] ea, input logic [2:0] eb,
                           input logic ec, input logic ev, input logic [1:0] es);
    check({name, ".a"}, 32'(a), 32'(ea));
    check({name, ".b"}, 32'(b), 32'(eb));
    check({name, ".cin"}, 32'(cin), 32'(ec));
    check({name, ".valid"}, 32'(valid), 32'(ev));
    check({name, ".stage"}, 32'(stage), 32'(es));
  endtask

  typedef struct {
    logic [2:0] sw;
    logic       sw_cin;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
    logic       exp_cin;
    logic       exp_valid;
    logic [1:0] exp_stage;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{3'd5, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0, 2'd1};
    vecs[1] = '{3'd6, 1'b0, 3'd5, 3'd6, 1'b0, 1'b0, 2'd2};
    vecs[2] = '{3'd2, 1'b1, 3'd5, 3'd6, 1'b1, 1'b1, 2'd3};
    vecs[3] = '{3'd7, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{3'd3, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 2'd1};

    // Reset state
    @(negedge clk);
    do_reset();
    check_all("reset", 3'd0, 3'd0, 1'b0, 1'b0, 2'd0);

    // Press latency: first low sample is edge 1, stage moves on edge DC+4
    sw = 3'd4;
    key_n = 1'b0;
    cycles(DC + 3);
    check("latency.before", 32'(stage), 32'd0);
    cycles(1);
    check("latency.stage", 32'(stage), 32'd1);
    check("latency.a", 32'(a), 32'd4);
    cycles(12);
    key_n = 1'b1; cycles(10);
    check("hold.single_press", 32'(stage), 32'd1);

    // Short glitches of 1..3 cycles must never be accepted
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      key_n = 1'b0; cycles(w);
      key_n = 1'b1; cycles(5);
    end
    check("glitch.stage", 32'(stage), 32'd0);
    // Counter must be back at zero: a fresh hold needs the full latency again
    sw = 3'd1;
    key_n = 1'b0;
    cycles(DC + 3);
    check("glitch.latency_before", 32'(stage), 32'd0);
    cycles(1);
    check("glitch.latency_after", 32'(stage), 32'd1);
    key_n = 1'b1; cycles(10);

    // Vector table: full A/B/cin/SHOW cycle with switch noise after each press
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sw = vecs[i].sw; sw_cin = vecs[i].sw_cin;
      clean_press();
      sw = ~vecs[i].sw; sw_cin = ~vecs[i].sw_cin;
      cycles(3);
      check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_cin, vecs[i].exp_valid, vecs[i].exp_stage);
      if (i == 2) begin
        check("vec.sum", 32'(a) + 32'(b) + 32'(cin), 32'd12);
        for (int t = 0; t < 6; t++) begin
          sw = 3'(t); sw_cin = t[0]; cycles(1);
        end
        check_all("show_hold", 3'd5, 3'd6, 1'b1, 1'b1, 2'd3);
      end
    end

    // Reset in ENTER_CIN discards operands
    do_reset();
    sw = 3'd7; clean_press(); clean_press();
    check_all("pre_reset", 3'd7, 3'd7, 1'b0, 1'b0, 2'd2);
    reset = 1'b1; cycles(1);
    check_all("mid_reset", 3'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0; cycles(2);

    // Reset coincident with the press pulse, key kept low across deassertion
    sw = 3'd6;
    key_n = 1'b0;
    cycles(DC + 3);
    reset = 1'b1; cycles(1);
    reset = 1'b0;
    check_all("reset_on_press", 3'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    cycles(DC + 3);
    check("redebounce.before", 32'(stage), 32'd0);
    cycles(1);
    check("redebounce.stage", 32'(stage), 32'd1);
    check("redebounce.a", 32'(a), 32'd6);
    cycles(10);
    key_n = 1'b1; cycles(10);
    check("redebounce.single", 32'(stage), 32'd1);

    // Bounce every cycle, then settle low: exactly one press
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key_n = i[0]; cycles(1);
    end
    key_n = 1'b0; cycles(10);
    key_n = 1'b1; cycles(10);
    check("bounce.stage", 32'(stage), 32'd1);

    // Random key activity and occasional resets against the model
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int len;
      logic lvl;
      len = $urandom_range(1, 12);
      lvl = 1'($urandom);
      for (int c = 0; c < len; c++) begin
        key_n  = lvl;
        sw     = 3'($urandom);
        sw_cin = 1'($urandom);
        reset  = ($urandom_range(0, 99) == 0);
        cycles(1);
        check("random", {a, b, cin, valid, stage},
              {m_a, m_b, m_cin, (m_stage == 2'd3), m_stage});
      end
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
